// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands with EX/MEM/WB forwarding,
// inserts bubbles for load-use hazards and branch flushes, and counts load-use bubbles.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_Rs1,
  input  logic [AW-1:0]   id_Rs2,
  input  logic [AW-1:0]   id_Rd,
  input  logic            id_RegW,
  input  logic            id_MemRead,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic [XLEN-1:0] ex_result,
  input  logic [AW-1:0]   mem_Rd,
  input  logic            mem_RegW,
  input  logic [XLEN-1:0] mem_result,
  input  logic [AW-1:0]   wb_Rd,
  input  logic            wb_RegW,
  input  logic [XLEN-1:0] wb_Wd,
  input  logic            flush,
  input  logic            ex_hold,
  output logic            stall,
  output logic            ex_valid,
  output logic            ex_RegW,
  output logic            ex_MemRead,
  output logic [AW-1:0]   ex_Rd,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic [15:0]     bubble_cnt
);

  logic             ex_valid_q, ex_valid_d;
  logic             ex_regw_q, ex_regw_d;
  logic             ex_memread_q, ex_memread_d;
  logic [AW-1:0]    ex_rd_q, ex_rd_d;
  logic [XLEN-1:0]  ex_op1_q, ex_op1_d;
  logic [XLEN-1:0]  ex_op2_q, ex_op2_d;
  logic [XLEN-1:0]  ex_imm_q, ex_imm_d;
  logic [XLEN-1:0]  ex_pc_q, ex_pc_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic            ex_fwd_ok;
  logic            load_use;
  logic [XLEN-1:0] op1_fwd, op2_fwd;

  // A load in EX has no data yet, so it must never feed the EX forward path.
  assign ex_fwd_ok = ex_valid_q & ex_regw_q & ~ex_memread_q;

  always_comb begin
    if (id_Rs1 == '0)                          op1_fwd = '0;
    else if (ex_fwd_ok && ex_rd_q == id_Rs1)   op1_fwd = ex_result;
    else if (mem_RegW && mem_Rd == id_Rs1)     op1_fwd = mem_result;
    else if (wb_RegW && wb_Rd == id_Rs1)       op1_fwd = wb_Wd;
    else                                       op1_fwd = rd1;
  end

  always_comb begin
    if (id_Rs2 == '0)                          op2_fwd = '0;
    else if (ex_fwd_ok && ex_rd_q == id_Rs2)   op2_fwd = ex_result;
    else if (mem_RegW && mem_Rd == id_Rs2)     op2_fwd = mem_result;
    else if (wb_RegW && wb_Rd == id_Rs2)       op2_fwd = wb_Wd;
    else                                       op2_fwd = rd2;
  end

  assign load_use = id_valid & ex_valid_q & ex_memread_q & (ex_rd_q != '0) &
                    ((ex_rd_q == id_Rs1) | (ex_rd_q == id_Rs2));

  assign stall = ex_hold | (load_use & ~flush);

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_regw_d    = ex_regw_q;
    ex_memread_d = ex_memread_q;
    ex_rd_d      = ex_rd_q;
    ex_op1_d     = ex_op1_q;
    ex_op2_d     = ex_op2_q;
    ex_imm_d     = ex_imm_q;
    ex_pc_d      = ex_pc_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush || (!ex_hold && load_use)) begin
      ex_valid_d   = 1'b0;
      ex_regw_d    = 1'b0;
      ex_memread_d = 1'b0;
      ex_rd_d      = '0;
      ex_op1_d     = '0;
      ex_op2_d     = '0;
      ex_imm_d     = '0;
      ex_pc_d      = '0;
      // Only genuine load-use bubbles are counted; flush bubbles are not.
      if (!flush && bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else if (!ex_hold) begin
      ex_valid_d   = id_valid;
      ex_regw_d    = id_RegW & id_valid;
      ex_memread_d = id_MemRead & id_valid;
      ex_rd_d      = id_Rd;
      ex_op1_d     = op1_fwd;
      ex_op2_d     = op2_fwd;
      ex_imm_d     = id_imm;
      ex_pc_d      = id_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid_q   <= 1'b0;
      ex_regw_q    <= 1'b0;
      ex_memread_q <= 1'b0;
      ex_rd_q      <= '0;
      ex_op1_q     <= '0;
      ex_op2_q     <= '0;
      ex_imm_q     <= '0;
      ex_pc_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_regw_q    <= ex_regw_d;
      ex_memread_q <= ex_memread_d;
      ex_rd_q      <= ex_rd_d;
      ex_op1_q     <= ex_op1_d;
      ex_op2_q     <= ex_op2_d;
      ex_imm_q     <= ex_imm_d;
      ex_pc_q      <= ex_pc_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_RegW    = ex_regw_q;
  assign ex_MemRead = ex_memread_q;
  assign ex_Rd      = ex_rd_q;
  assign ex_op1     = ex_op1_q;
  assign ex_op2     = ex_op2_q;
  assign ex_imm     = ex_imm_q;
  assign ex_pc      = ex_pc_q;
  // A narrower counter saturates at its own all-ones value, zero-extended here.
  assign bubble_cnt = 16'(bubble_cnt_q);

endmodule
